// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - packet-aware 1-to-4 stream demultiplexer with one-entry output registers
//
// Purpose: routes each upstream packet to one of four output channels. The
//    channel is chosen by in_sel on the first beat of a packet and held for
//    the rest of the packet. Every channel has its own one-entry register, so
//    a stalled channel never blocks the draining of the others.
//
// Ports:
//    clk, rst_n              clock, asynchronous active-low reset
//    in_valid/in_ready       upstream handshake
//    in_data, in_sel, in_last upstream payload, destination, end-of-packet
//    out_valid/out_ready     per-channel downstream handshake (bit i = channel i)
//    out_data                channel i at bits [i*WIDTH +: WIDTH]
//    out_last                end-of-packet flag stored with each channel's beat
//    busy                    high while inside a multi-beat packet

module demux_stream #(
   parameter int WIDTH = 8,
   parameter int NOUT  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_data,
   input  logic [1:0]            in_sel,
   input  logic                  in_last,
   output logic [NOUT-1:0]       out_valid,
   input  logic [NOUT-1:0]       out_ready,
   output logic [NOUT*WIDTH-1:0] out_data,
   output logic [NOUT-1:0]       out_last,
   output logic                  busy
);

   typedef enum logic {
      IDLE = 1'b0,
      PKT  = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [1:0]      cur_sel;
   logic [1:0]      target;
   logic            accept;
   logic [NOUT-1:0] wr;

   // Inside a packet the latched channel wins; in_sel only matters on a first beat.
   assign target = (state == PKT) ? cur_sel : in_sel;

   // A full register that drains this cycle can take the next beat with no bubble.
   assign in_ready = !out_valid[target] || out_ready[target];
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr = '0;
      if (accept) begin
         wr[target] = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cur_sel <= 2'd0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && accept && !in_last) begin
            cur_sel <= in_sel;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && !in_last) state_nxt = PKT;
         PKT:     if (accept && in_last)  state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      busy = (state == PKT);
   end

   // Channel registers: a write always wins over a drain, so a simultaneous
   // drain and write leaves the channel valid with the new beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= '0;
         out_last  <= '0;
         out_data  <= '0;
      end else begin
         for (int i = 0; i < NOUT; i++) begin
            if (wr[i]) begin
               out_valid[i]                <= 1'b1;
               out_last[i]                 <= in_last;
               out_data[i*WIDTH +: WIDTH]  <= in_data;
            end else if (out_ready[i]) begin
               out_valid[i] <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_demux_stream.sv
// tb/tb_demux_stream.sv - self-checking bench for demux_stream

module tb_demux_stream;

   localparam int W = 8;

   logic           clk       = 1'b0;
   logic           rst_n     = 1'b0;
   logic           in_valid  = 1'b0;
   logic           in_ready;
   logic [W-1:0]   in_data   = '0;
   logic [1:0]     in_sel    = 2'd0;
   logic           in_last   = 1'b0;
   logic [3:0]     out_valid;
   logic [3:0]     out_ready = 4'hF;
   logic [4*W-1:0] out_data;
   logic [3:0]     out_last;
   logic           busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   demux_stream #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: each channel is a queue of {last,data} beats still owed to its
   // consumer; a channel holds at most one beat, so "valid" is "queue not empty".
   logic [W:0] q [4][$];
   bit         m_pkt = 1'b0;
   logic [1:0] m_sel = 2'd0;

   function automatic logic [1:0] m_target();
      return m_pkt ? m_sel : in_sel;
   endfunction

   function automatic bit m_ready();
      logic [1:0] t;
      t = m_target();
      return (q[t].size() == 0) || out_ready[t];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) q[i].delete();
      m_pkt = 1'b0;
      m_sel = 2'd0;
   endtask

   task automatic model_step();
      logic [1:0] t;
      bit         acc;
      t   = m_target();
      acc = in_valid && m_ready();
      for (int i = 0; i < 4; i++) begin
         if (q[i].size() != 0 && out_ready[i]) void'(q[i].pop_front());
      end
      if (acc) begin
         q[t].push_back({in_last, in_data});
         if (!m_pkt && !in_last) begin
            m_pkt = 1'b1;
            m_sel = in_sel;
         end else if (m_pkt && in_last) begin
            m_pkt = 1'b0;
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) model_reset();
      else        model_step();
   end

   // Compare process: every falling edge, all outputs against the model.
   always @(negedge clk) begin
      logic [3:0] ev;
      logic [W:0] b;
      ev = '0;
      for (int i = 0; i < 4; i++) ev[i] = (q[i].size() != 0);
      chk("cmp_out_valid", out_valid, ev);
      chk("cmp_busy", busy, m_pkt);
      chk("cmp_in_ready", in_ready, m_ready());
      for (int i = 0; i < 4; i++) begin
         if (q[i].size() != 0) begin
            b = q[i][0];
            chk($sformatf("cmp_data_ch%0d", i), out_data[i*W +: W], b[W-1:0]);
            chk($sformatf("cmp_last_ch%0d", i), out_last[i], b[W]);
         end
      end
   end

   task automatic put(input logic v, input logic [1:0] sel, input logic [W-1:0] d, input logic last);
      in_valid = v;
      in_sel   = sel;
      in_data  = d;
      in_last  = last;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_out_valid", out_valid, 4'b0000);
      chk("rst_out_last", out_last, 4'b0000);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      rst_n = 1'b1;
      tick();

      // Single beat to channel 2
      put(1, 2'd2, 8'hA5, 1);
      tick();
      put(0, 2'd0, 8'h00, 0);
      chk("single_valid", out_valid, 4'b0100);
      chk("single_data", out_data[23:16], 8'hA5);
      chk("single_last", out_last[2], 1'b1);
      chk("single_busy", busy, 1'b0);
      tick();

      // Three-beat packet; in_sel changes mid-packet and must be ignored
      put(1, 2'd1, 8'h11, 0);
      tick();
      chk("pkt_b1_busy", busy, 1'b1);
      chk("pkt_b1_valid", out_valid, 4'b0010);
      chk("pkt_b1_data", out_data[15:8], 8'h11);
      put(1, 2'd3, 8'h22, 0);
      tick();
      chk("pkt_b2_busy", busy, 1'b1);
      chk("pkt_b2_valid", out_valid, 4'b0010);
      chk("pkt_b2_data", out_data[15:8], 8'h22);
      put(1, 2'd3, 8'h33, 1);
      tick();
      chk("pkt_b3_busy", busy, 1'b0);
      chk("pkt_b3_valid", out_valid, 4'b0010);
      chk("pkt_b3_data", out_data[15:8], 8'h33);
      chk("pkt_b3_last", out_last[1], 1'b1);
      put(0, 2'd0, 8'h00, 0);
      tick();

      // Back-pressure on channel 0
      out_ready = 4'b1110;
      put(1, 2'd0, 8'h44, 0);
      tick();
      chk("bp_b1_valid", out_valid, 4'b0001);
      chk("bp_b1_data", out_data[7:0], 8'h44);
      put(1, 2'd0, 8'h55, 1);
      #1;
      chk("bp_b2_ready", in_ready, 1'b0);
      tick();
      chk("bp_hold_data", out_data[7:0], 8'h44);
      chk("bp_hold_ready", in_ready, 1'b0);
      out_ready = 4'b1111;
      #1;
      chk("bp_release_ready", in_ready, 1'b1);
      tick();
      chk("bp_b2_data", out_data[7:0], 8'h55);
      chk("bp_b2_valid", out_valid, 4'b0001);
      chk("bp_b2_busy", busy, 1'b0);
      put(0, 2'd0, 8'h00, 0);
      tick();

      // Independence: channel 0 stalled full, single beat to channel 3
      out_ready = 4'b1110;
      put(1, 2'd0, 8'h66, 1);
      tick();
      put(1, 2'd3, 8'h77, 1);
      #1;
      chk("ind_ready", in_ready, 1'b1);
      tick();
      put(0, 2'd0, 8'h00, 0);
      chk("ind_valid", out_valid, 4'b1001);
      chk("ind_ch3_data", out_data[31:24], 8'h77);
      chk("ind_ch0_data", out_data[7:0], 8'h66);
      out_ready = 4'hF;
      tick();

      // Streaming 16 beats to channel 2
      for (int k = 0; k < 16; k++) begin
         put(1, 2'd2, 8'h80 + W'(k), (k == 15));
         #1;
         chk($sformatf("stream_ready_%0d", k), in_ready, 1'b1);
         tick();
         chk($sformatf("stream_data_%0d", k), out_data[23:16], 8'h80 + W'(k));
         chk($sformatf("stream_valid_%0d", k), out_valid, 4'b0100);
      end
      put(0, 2'd0, 8'h00, 0);
      tick();

      // Reset in the middle of a 4-beat packet to channel 1
      put(1, 2'd1, 8'h91, 0);
      tick();
      put(1, 2'd1, 8'h92, 0);
      tick();
      put(0, 2'd0, 8'h00, 0);
      chk("mr_pre_busy", busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid", out_valid, 4'b0000);
      chk("mr_busy", busy, 1'b0);
      tick();
      rst_n = 1'b1;
      put(1, 2'd0, 8'hC3, 0);
      tick();
      chk("mr_new_valid", out_valid, 4'b0001);
      chk("mr_new_data", out_data[7:0], 8'hC3);
      chk("mr_new_busy", busy, 1'b1);
      put(1, 2'd2, 8'hC4, 1);
      tick();
      chk("mr_b2_valid", out_valid, 4'b0001);
      chk("mr_b2_data", out_data[7:0], 8'hC4);
      chk("mr_b2_busy", busy, 1'b0);
      put(0, 2'd0, 8'h00, 0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
